mem_mapped_timer: RTL and testbench
===================================

# mem_mapped_timer

Memory-mapped RISC-V machine timer on the CPU data-memory port, alongside `ram`. It decodes `memory_address` against a base window and maintains a 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register. It raises a registered `timer_irq` when the counter reaches the compare value. The top level muxes `rd` into the CPU's `memory_out` whenever `sel` is high.

## Interface
- `BASE_ADDR`, default 32'h0000_1000: window base; must be aligned to 32 bytes.
- `RESET_CMP`, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `a`, input, 32: byte address from the CPU memory port.
- `we`, input, 1: write strobe.
- `write_byte_enable`, input, 4: per-byte write enable; bit i selects `wd[8i+7:8i]`.
- `wd`, input, 32: write data.
- `rd`, output, 32: combinational read data; 0 when `sel` is low.
- `sel`, output, 1: combinational; high when `a[31:5] == BASE_ADDR[31:5]`.
- `timer_irq`, output, 1: registered interrupt level.

## Operation
- Register map, word offset `a[4:2]`; `a[1:0]` ignored:
  - 0: `mtime[31:0]`
  - 1: `mtime[63:32]`
  - 2: `mtimecmp[31:0]`
  - 3: `mtimecmp[63:32]`
  - 4: `ctrl`. Bit0 `en`, bit1 `irq_mask`; upper bits read 0, writes to them ignored.
  - 5: `prescale`. Only present with the macro; otherwise reads 0, writes ignored.
  - 6–7: read 0, writes ignored.
- Writes: occur when `we && sel`. Only the enabled bytes change.
- Counter: increments by 1 on each tick while `en`=1; 64-bit arithmetic.
  - Wrap-around: 64'hFFFF_FFFF_FFFF_FFFF becomes 0.
- Write to `mtime` in the same cycle as a tick: the written bytes take the written value. All other bytes hold their pre-edge values. No increment is applied that cycle.
- Compare: `match = (mtime >= mtimecmp)`, unsigned 64-bit, evaluated on current register values.
- `timer_irq` next value: `en && !irq_mask && match`.
  - It is a level, not sticky. It clears by writing `mtimecmp` above `mtime`, or by clearing `en`, or by setting `irq_mask`.
- No access to the window (`we` low, or `sel` low) has side effects; reads never have side effects.

## Timing
- Reset values (asynchronous):
  - `mtime`=0, `mtimecmp`=`RESET_CMP`, `ctrl`=0.
  - `prescale`=0, internal prescaler counter=0.
  - `timer_irq`=0.
- `rd` and `sel` follow `a` combinationally in the same cycle.
- Write latency: a written value is readable on `rd` in the cycle after the write edge.
- Counting: with `en` set at edge N, the first increment occurs at edge N+1.
- Interrupt: `timer_irq` rises one edge after `match` becomes true. Example: `mtime` reaches the compare value after edge K; `timer_irq` is high after edge K+1.
- Reset mid-count forces all state to reset values immediately. Counting resumes only after software sets `en`.

## Configuration
- `MEM_MAPPED_TIMER_PRESCALER_EN` defined:
  - Offset 5 is a 16-bit read/write `prescale` register.
  - A tick occurs once every `prescale`+1 enabled cycles, using an internal down-counter.
  - The down-counter reloads whenever `prescale` is written or `en` goes 0.
- Macro undefined: every enabled cycle is a tick, and offset 5 reads 0.

## Structure
- The shared package `cpu_types` gains:
  - a `timer_reg_e` enum for the word offsets 0–5;
  - `TIMER_CTRL_EN_BIT` = 0 and `TIMER_CTRL_MASK_BIT` = 1.
- One sub-module, `byte_merge`, is natural. It is combinational and applies `write_byte_enable` to (old word, `wd`) and returns the new word. It is reused for all writable registers.

## Test plan
- Reset, then read offsets 0–4:
  - `rd` = 0, 0, FFFF_FFFF, FFFF_FFFF, 0.
  - `timer_irq`=0.
- Write ctrl=1 and hold for 10 cycles, then read offset 0: `rd`=10.
  - `sel`=0 and `rd`=0 for address 0x0000_2000.
- Write mtime lo=FFFF_FFFF and hi=0, enable, and wait one tick: hi=1, lo=0 (carry). A separate case loads all-ones; after one tick, both words read 0 (wrap).
- Write mtimecmp=5 (hi=0) and enable from 0:
  - `timer_irq` is first high one cycle after `mtime`=5.
  - Setting ctrl bit1 drops `timer_irq` one cycle later.
- With ctrl enabled, write mtime lo with byte enable 4'b0001 and `wd`=0x0000_00AB on a tick cycle: the next read is the old upper 24 bits with low byte 0xAB, with no increment applied that cycle.
- With `MEM_MAPPED_TIMER_PRESCALER_EN` and `prescale`=3: after 12 enabled cycles, `mtime`=3. A mid-count `rst_n` pulse returns every output to its reset value.

Source files
------------

// File: rtl/mem_mapped_timer_pkg.sv
// ============================================================================
// Module      : cpu_types (package)
// Description : Shared CPU type definitions. This file holds the timer
//               register-map enum and the ctrl bit positions that the
//               memory-mapped timer uses.
// Revision    : 1.0 - initial timer additions
// ============================================================================
`default_nettype none

package cpu_types;

  // Word offsets within the 32-byte timer window. a[4:2] selects the word.
  typedef enum logic [2:0] {
    TIMER_MTIME_LO    = 3'd0,
    TIMER_MTIME_HI    = 3'd1,
    TIMER_MTIMECMP_LO = 3'd2,
    TIMER_MTIMECMP_HI = 3'd3,
    TIMER_CTRL        = 3'd4,
    TIMER_PRESCALE    = 3'd5
  } timer_reg_e;

  localparam int TIMER_CTRL_EN_BIT   = 0;
  localparam int TIMER_CTRL_MASK_BIT = 1;

endpackage

`default_nettype wire

// File: rtl/byte_merge.sv
// ============================================================================
// Module      : byte_merge
// Description : Combinational byte-lane merge. Each lane whose enable bit is
//               set takes its byte from wd. Every other lane keeps its byte
//               from old_word.
// Ports       : old_word          - current register contents
//               wd                - write data from the CPU
//               write_byte_enable - bit i enables lane [8i+7:8i]
//               new_word          - merged result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] wd,
  input  logic [3:0]  write_byte_enable,
  output logic [31:0] new_word
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign new_word[8*i +: 8] = write_byte_enable[i] ? wd[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/mem_mapped_timer.sv
// ============================================================================
// Module      : mem_mapped_timer
// Description : RISC-V style machine timer on the CPU data-memory port.
//               It provides a 64-bit mtime counter, a 64-bit mtimecmp
//               register, a ctrl register (en, irq_mask) and a registered
//               timer_irq level. Build option: defining
//               MEM_MAPPED_TIMER_PRESCALER_EN adds a 16-bit prescale register
//               at word offset 5, so one tick occurs every prescale+1
//               enabled cycles.
// Ports       : clk, rst_n          - clock, async active-low reset
//               a                   - byte address (a[1:0] ignored)
//               we                  - write strobe
//               write_byte_enable   - per-byte write enable
//               wd                  - write data
//               rd                  - read data, 0 when sel is low
//               sel                 - address falls inside the window
//               timer_irq           - registered interrupt level
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_mapped_timer
  import cpu_types::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic        we,
  input  logic [3:0]  write_byte_enable,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        timer_irq
);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_en;
  logic        r_mask;
  logic        r_irq;

  logic [2:0]  w_off;
  logic        w_wr;
  logic [31:0] w_word;
  logic [31:0] w_merged;
  logic        w_tick;
  logic        w_wr_time_lo;
  logic        w_wr_time_hi;
  logic        w_wr_cmp_lo;
  logic        w_wr_cmp_hi;
  logic        w_wr_ctrl;
  logic        w_unused;

`ifdef MEM_MAPPED_TIMER_PRESCALER_EN
  logic [15:0] r_prescale;
  logic [15:0] r_psc_cnt;
  logic        w_wr_psc;
  logic        w_psc_reload;
`endif

  assign sel      = (a[31:5] == BASE_ADDR[31:5]);
  assign w_off    = a[4:2];
  assign w_wr     = we && sel;
  assign w_unused = &{1'b0, a[1:0]};

  assign w_wr_time_lo = w_wr && (w_off == TIMER_MTIME_LO);
  assign w_wr_time_hi = w_wr && (w_off == TIMER_MTIME_HI);
  assign w_wr_cmp_lo  = w_wr && (w_off == TIMER_MTIMECMP_LO);
  assign w_wr_cmp_hi  = w_wr && (w_off == TIMER_MTIMECMP_HI);
  assign w_wr_ctrl    = w_wr && (w_off == TIMER_CTRL);

  // The addressed word is decoded independently of sel. It is used for the
  // read path and also as the "old" operand of the single shared byte merge.
  always_comb begin
    w_word = 32'd0;
    case (w_off)
      TIMER_MTIME_LO:    w_word = r_mtime[31:0];
      TIMER_MTIME_HI:    w_word = r_mtime[63:32];
      TIMER_MTIMECMP_LO: w_word = r_mtimecmp[31:0];
      TIMER_MTIMECMP_HI: w_word = r_mtimecmp[63:32];
      TIMER_CTRL: begin
        w_word[TIMER_CTRL_EN_BIT]   = r_en;
        w_word[TIMER_CTRL_MASK_BIT] = r_mask;
      end
`ifdef MEM_MAPPED_TIMER_PRESCALER_EN
      TIMER_PRESCALE:    w_word = {16'd0, r_prescale};
`endif
      default:           w_word = 32'd0;
    endcase
  end

  assign rd = sel ? w_word : 32'd0;

  byte_merge u_byte_merge (
    .old_word          (w_word),
    .wd                (wd),
    .write_byte_enable (write_byte_enable),
    .new_word          (w_merged)
  );

`ifdef MEM_MAPPED_TIMER_PRESCALER_EN
  assign w_wr_psc     = w_wr && (w_off == TIMER_PRESCALE);
  // The down-counter restarts from the prescale value while disabled or when
  // prescale is rewritten. Otherwise it ticks when it has counted down to 0.
  assign w_psc_reload = !r_en || w_wr_psc;
  assign w_tick       = !w_psc_reload && (r_psc_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale <= 16'd0;
      r_psc_cnt  <= 16'd0;
    end else begin
      if (w_wr_psc) begin
        r_prescale <= w_merged[15:0];
      end
      if (w_psc_reload) begin
        r_psc_cnt <= w_wr_psc ? w_merged[15:0] : r_prescale;
      end else if (r_psc_cnt == 16'd0) begin
        r_psc_cnt <= r_prescale;
      end else begin
        r_psc_cnt <= r_psc_cnt - 16'd1;
      end
    end
  end
`else
  assign w_tick = r_en;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime    <= 64'd0;
      r_mtimecmp <= RESET_CMP;
      r_en       <= 1'b0;
      r_mask     <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      // A software write to either half of mtime suppresses that cycle's
      // increment. The untouched half keeps its pre-edge value.
      if (w_wr_time_lo || w_wr_time_hi) begin
        if (w_wr_time_lo) r_mtime[31:0]  <= w_merged;
        if (w_wr_time_hi) r_mtime[63:32] <= w_merged;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end

      if (w_wr_cmp_lo) r_mtimecmp[31:0]  <= w_merged;
      if (w_wr_cmp_hi) r_mtimecmp[63:32] <= w_merged;

      if (w_wr_ctrl) begin
        r_en   <= w_merged[TIMER_CTRL_EN_BIT];
        r_mask <= w_merged[TIMER_CTRL_MASK_BIT];
      end

      // Level interrupt from current register values, one edge after match.
      r_irq <= r_en && !r_mask && (r_mtime >= r_mtimecmp);
    end
  end

  assign timer_irq = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_mem_mapped_timer.sv
// ============================================================================
// Module      : tb_mem_mapped_timer
// Description : Self-checking bench for mem_mapped_timer. A register-level
//               model is kept in plain variables and updated on each clock
//               edge. Directed scenarios are followed by randomized bus
//               traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_mapped_timer;

  localparam logic [31:0] BASE    = 32'h0000_1000;
  localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = 32'd0;
  logic        we = 1'b0;
  logic [3:0]  write_byte_enable = 4'd0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        sel;
  logic        timer_irq;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic        m_en;
  logic        m_mask;
  logic        m_irq;
  logic [15:0] m_psc;
  int          m_since;

  mem_mapped_timer #(
    .BASE_ADDR (BASE),
    .RESET_CMP (CMP_RST)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .a                 (a),
    .we                (we),
    .write_byte_enable (write_byte_enable),
    .wd                (wd),
    .rd                (rd),
    .sel               (sel),
    .timer_irq         (timer_irq)
  );

  always #5 clk = ~clk;

  function automatic bit in_win(input logic [31:0] addr);
    return addr[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] addr);
    if (!in_win(addr)) return 32'd0;
    case (addr[4:2])
      3'd0: return m_time[31:0];
      3'd1: return m_time[63:32];
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {30'd0, m_mask, m_en};
`ifdef MEM_MAPPED_TIMER_PRESCALER_EN
      3'd5: return {16'd0, m_psc};
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_time  = 64'd0;
    m_cmp   = CMP_RST;
    m_en    = 1'b0;
    m_mask  = 1'b0;
    m_irq   = 1'b0;
    m_psc   = 16'd0;
    m_since = 0;
  endtask

  // One rising edge of the model, from the pre-edge state and bus inputs.
  task automatic model_edge(input logic [31:0] addr, input bit w,
                            input logic [3:0] be, input logic [31:0] data);
    bit          hit;
    bit          tick;
    int          off;
    logic [31:0] msk;
    logic [63:0] nt;
    logic [63:0] nc;
    logic        nirq;
    hit  = w && in_win(addr);
    off  = int'(addr[4:2]);
    msk  = bmask(be);
    nirq = m_en && !m_mask && (m_time >= m_cmp);
`ifdef MEM_MAPPED_TIMER_PRESCALER_EN
    if (!m_en || (hit && off == 5)) begin
      m_since = 0;
      tick    = 1'b0;
    end else begin
      m_since = m_since + 1;
      tick    = (m_since == int'(m_psc) + 1);
      if (tick) m_since = 0;
    end
    if (hit && off == 5) m_psc = (m_psc & ~msk[15:0]) | (data[15:0] & msk[15:0]);
`else
    tick = m_en;
`endif
    nt = m_time;
    nc = m_cmp;
    if (hit && off == 0) nt[31:0]  = (m_time[31:0]  & ~msk) | (data & msk);
    if (hit && off == 1) nt[63:32] = (m_time[63:32] & ~msk) | (data & msk);
    if (!(hit && (off == 0 || off == 1)) && tick) nt = m_time + 64'd1;
    if (hit && off == 2) nc[31:0]  = (m_cmp[31:0]  & ~msk) | (data & msk);
    if (hit && off == 3) nc[63:32] = (m_cmp[63:32] & ~msk) | (data & msk);
    if (hit && off == 4 && be[0]) begin
      m_en   = data[0];
      m_mask = data[1];
    end
    m_time = nt;
    m_cmp  = nc;
    m_irq  = nirq;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one bus cycle and return at the following falling edge.
  task automatic step(input logic [31:0] addr, input bit w,
                      input logic [3:0] be, input logic [31:0] data);
    a = addr; we = w; write_byte_enable = be; wd = data;
    @(posedge clk);
    model_edge(addr, w, be, data);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wr(input int off, input logic [31:0] data);
    step(BASE + 32'(off * 4), 1'b1, 4'hF, data);
  endtask

  task automatic idle();
    step(a, 1'b0, 4'h0, 32'd0);
  endtask

  // Combinational read within the current low clock phase.
  task automatic chk_rd(input string tag, input logic [31:0] addr);
    a = addr; we = 1'b0;
    #1;
    chk(tag, {32'd0, rd}, {32'd0, mdl_rd(addr)});
  endtask

  task automatic chk_irq(input string tag);
    chk(tag, {63'd0, timer_irq}, {63'd0, m_irq});
  endtask

  logic [31:0] old_lo;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    // Reset values, read while reset is held
    chk_irq("rst_irq");
    chk("rst_cmp_hi_const", {32'd0, mdl_rd(BASE + 32'd12)}, 64'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      chk_rd($sformatf("rst_rd%0d", i), BASE + 32'(i * 4));
      @(negedge clk);
    end
    rst_n = 1'b1;
    idle();
    chk_rd("rst_rd0_rel", BASE);
    chk("rst_rd0_zero", {32'd0, rd}, 64'd0);
    chk_rd("rst_rd3_rel", BASE + 32'd12);
    chk("rst_rd3_ones", {32'd0, rd}, 64'hFFFF_FFFF);

    // Enable and count ten edges
    wr(4, 32'd1);
    repeat (10) idle();
    chk_rd("cnt10", BASE);
    chk("cnt10_const", {32'd0, rd}, 64'd10);

    // Outside the window
    a = 32'h0000_2000; #1;
    chk("out_sel", {63'd0, sel}, 64'd0);
    chk("out_rd", {32'd0, rd}, 64'd0);

    // Carry from lo into hi
    wr(4, 32'd0);
    wr(0, 32'hFFFF_FFFF);
    wr(1, 32'd0);
    wr(4, 32'd1);
    idle();
    chk_rd("carry_lo", BASE);
    chk("carry_lo_const", {32'd0, rd}, 64'd0);
    chk_rd("carry_hi", BASE + 32'd4);
    chk("carry_hi_const", {32'd0, rd}, 64'd1);

    // 64-bit wrap
    wr(4, 32'd0);
    wr(0, 32'hFFFF_FFFF);
    wr(1, 32'hFFFF_FFFF);
    wr(4, 32'd1);
    idle();
    chk_rd("wrap_lo", BASE);
    chk("wrap_lo_const", {32'd0, rd}, 64'd0);
    chk_rd("wrap_hi", BASE + 32'd4);
    chk("wrap_hi_const", {32'd0, rd}, 64'd0);

    // Interrupt at mtimecmp = 5
    wr(4, 32'd0);
    wr(0, 32'd0);
    wr(1, 32'd0);
    wr(2, 32'd5);
    wr(3, 32'd0);
    wr(4, 32'd1);
    repeat (5) begin
      idle();
      chk_irq("irq_wait");
    end
    chk_rd("irq_mtime5", BASE);
    chk("irq_mtime5_const", {32'd0, rd}, 64'd5);
    chk("irq_low_at5", {63'd0, timer_irq}, 64'd0);
    idle();
    chk("irq_high_at6", {63'd0, timer_irq}, 64'd1);
    wr(4, 32'd3);
    chk("irq_mask_edge", {63'd0, timer_irq}, 64'd1);
    idle();
    chk("irq_masked", {63'd0, timer_irq}, 64'd0);
    chk_irq("irq_masked_mdl");

    // Partial byte write on a tick cycle
    wr(4, 32'd1);
    wr(0, 32'h1234_5678);
    idle();
    old_lo = m_time[31:0];
    step(BASE, 1'b1, 4'b0001, 32'h0000_00AB);
    chk_rd("pbw_lo", BASE);
    chk("pbw_lo_const", {32'd0, rd}, {32'd0, old_lo[31:8], 8'hAB});
    chk_rd("pbw_hi", BASE + 32'd4);

`ifdef MEM_MAPPED_TIMER_PRESCALER_EN
    wr(4, 32'd0);
    wr(0, 32'd0);
    wr(1, 32'd0);
    wr(5, 32'd3);
    wr(4, 32'd1);
    repeat (12) idle();
    chk_rd("psc_mtime", BASE);
    chk("psc_mtime_const", {32'd0, rd}, 64'd3);
`else
    wr(5, 32'hFFFF_FFFF);
    chk_rd("psc_absent", BASE + 32'd20);
    chk("psc_absent_const", {32'd0, rd}, 64'd0);
`endif

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      logic [31:0] ad;
      logic [31:0] dv;
      if ($urandom_range(0, 9) != 0)
        ad = BASE + 32'($urandom_range(0, 31));
      else
        ad = $urandom;
      dv = $urandom;
      if (ad[4:2] == 3'd4 && $urandom_range(0, 3) != 0) dv[0] = 1'b1;
      if (ad[4:2] == 3'd5) dv[15:3] = 13'd0;
      if (ad[4:2] == 3'd3 && $urandom_range(0, 1) != 0) dv = 32'd0;
      step(ad, ($urandom_range(0, 1) == 1), 4'($urandom), dv);
      chk_irq("rnd_irq");
      if ($urandom_range(0, 3) == 0) chk_rd("rnd_rd_out", $urandom);
      else chk_rd("rnd_rd", BASE + 32'($urandom_range(0, 31)));
    end

    // Asynchronous reset in the middle of counting
    wr(2, 32'd0);
    wr(3, 32'd0);
    wr(4, 32'd1);
    repeat (3) idle();
    chk("mid_irq_before", {63'd0, timer_irq}, 64'd1);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk_irq("mid_irq_rst");
    chk_rd("mid_rd0", BASE);
    @(negedge clk);
    for (int i = 1; i < 5; i++) chk_rd($sformatf("mid_rd%0d", i), BASE + 32'(i * 4));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) idle();
    chk_rd("mid_no_resume", BASE);
    chk("mid_no_resume_const", {32'd0, rd}, 64'd0);
    chk_irq("mid_irq_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
